posit_accumulator: RTL and testbench
====================================

Name: posit_accumulator

Overview:
Sequential accumulation controller that sits directly downstream of, and feeds back into, the combinational Posit_Adder. It accepts a stream of posit operands over a valid/ready handshake and drives the adder with the current running sum and the incoming operand. It registers each sum and emits the final posit result on an output handshake. This turns the single-shot adder into a reduction engine, for example for dot-product and associativity sweeps.

Parameters:
N, 32, posit word width; must match the Posit_Adder instance.
ES, 4, posit exponent field width; documentation only, and passed to the adder instance by the parent.
LW, 8, width of the operand-count (length) field and of the beat counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a reduction; sampled only in IDLE.
len  in  LW  number of operands to accumulate; sampled with start.
init  in  N  initial accumulator posit; sampled with start.
in_valid  in  1  operand valid.
in_data  in  N  operand posit.
in_ready  out  1  operand accepted this cycle when in_valid && in_ready.
add_a  out  N  adder operand A; always equals the accumulator register.
add_b  out  N  adder operand B; always equals in_data.
add_sum  in  N  adder result (the OUT of Posit_Adder).
out_valid  out  1  result valid.
out_data  out  N  final accumulated posit.
out_ready  in  1  result consumed when out_valid && out_ready.
busy  out  1  high in ACC and DONE.
beat_cnt  out  LW  operands accepted in the current reduction.

Behaviour:
- Reset (asynchronous, rst_n low) takes effect immediately regardless of clk:
  - state = IDLE.
  - acc = 0, remaining = 0, beat_cnt = 0.
  - in_ready = 0, out_valid = 0, out_data = 0, busy = 0.
- Reset mid-operation aborts the reduction with no output. Any operand offered in the reset cycle is not consumed.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - start=1 and len != 0: acc <= init, remaining <= len, beat_cnt <= 0; go to ACC.
  - start=1 and len == 0: out_data <= init, out_valid <= 1; go to DONE. The adder is not used.
- ACC:
  - in_ready = 1, driven combinationally from state.
  - On a beat: acc <= add_sum, remaining <= remaining-1, beat_cnt <= beat_cnt+1.
  - On the beat where remaining == 1: out_data <= add_sum, out_valid <= 1; go to DONE.
  - No beat: all state held. in_valid may bubble arbitrarily.
- DONE:
  - in_ready = 0.
  - out_valid and out_data are held stable until out_ready=1, then out_valid <= 0; go to IDLE.
  - beat_cnt keeps its final value until the next start.
- start is ignored outside IDLE.
- add_a and add_b are purely combinational and always driven. add_sum is sampled only on a beat.
- Timing:
  - Throughput is 1 operand per cycle.
  - out_valid rises in the cycle after the last beat.
  - Minimum start-to-out_valid is len+1 cycles.
  - out_valid may be accepted in the same cycle it rises. IDLE then follows one cycle later.
- Arithmetic: all posit rounding and saturation come from the adder; the block does no arithmetic on posit fields.
  - beat_cnt wraps naturally at LW bits; with len <= 2^LW-1 it never wraps.
- Posit encodings used here: NaR = 1 followed by N-1 zeros (0x80000000 at N=32); zero = all zeros.

Optional Feature:
Macro POSIT_ACC_NAR_STICKY_EN.
- Defined:
  - A flag nar_seen clears on start.
  - It sets when a beat carries in_data == NaR, or when add_sum == NaR on a beat.
  - Once nar_seen is set, acc is forced to NaR and subsequent add_sum is ignored.
  - Remaining operands are still consumed to keep the stream aligned. out_data = NaR.
  - init == NaR also sets the flag at start.
- Undefined:
  - No flag exists; acc always takes add_sum.
  - NaR propagation depends solely on the adder's behaviour.

Test Plan:
1. start, len=3, init=0x00000000; beats 0x40000000 x3 (1.0 each) -> out_data=0x43000000 (3.0), beat_cnt=3, out_valid exactly 4 cycles after start with back-to-back in_valid.
2. start, len=0, init=0x40000000 -> out_valid next cycle, out_data=0x40000000, in_ready never high, add_sum never sampled.
3. len=2, init=0, beats 0x40000000 then 0xC0000000 (-1.0) with 3 idle cycles between -> out_data=0x00000000; acc and beat_cnt held during bubbles.
4. Result back-pressure: out_ready=0 for 5 cycles after out_valid -> out_valid/out_data stable; start pulses ignored; IDLE one cycle after out_ready=1.
5. Reset: assert rst_n=0 asynchronously after 2 of 4 beats -> all outputs 0 immediately, no out_valid; a new start with len=1, init=0x40000000, beat 0x40000000 gives 0x42000000.
6. With POSIT_ACC_NAR_STICKY_EN: len=3, beats 0x40000000, 0x80000000, 0x40000000 -> out_data=0x80000000, beat_cnt=3. Without the macro, the result equals the adder's output chain.

Source files
------------

// File: rtl/posit_accumulator_if.sv
// Handshake and adder-feedback bundle between a posit_accumulator and its parent.
// The slave modport is the accumulator's view; the master modport is the parent's view.
interface posit_accumulator_if #(
  parameter int N  = 32,
  parameter int LW = 8
);
  logic          start;
  logic [LW-1:0] len;
  logic [N-1:0]  init;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic [N-1:0]  add_a;
  logic [N-1:0]  add_b;
  logic [N-1:0]  add_sum;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          out_ready;
  logic          busy;
  logic [LW-1:0] beat_cnt;

  modport master (
    output start, len, init, in_valid, in_data, add_sum, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_data, busy, beat_cnt
  );

  modport slave (
    input  start, len, init, in_valid, in_data, add_sum, out_ready,
    output in_ready, add_a, add_b, out_valid, out_data, busy, beat_cnt
  );
endinterface

// File: rtl/posit_accumulator.sv
// Reduction controller wrapped around an external combinational posit adder.
// Optional sticky-NaR tracking is enabled by defining POSIT_ACC_NAR_STICKY_EN.
module posit_accumulator #(
  parameter int N  = 32,
  parameter int ES = 4,
  parameter int LW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  posit_accumulator_if.slave  bus
);

  // ES only has to agree with the adder; reject encodings with no room for a regime.
  if (ES > N - 3) begin : g_es_range_check
    $error("posit_accumulator: ES too large for N");
  end

  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_acc;
  logic [LW-1:0] r_remaining;
  logic [LW-1:0] r_beat_cnt;
  logic          r_out_valid;
  logic [N-1:0]  r_out_data;

  logic          w_beat;
  logic [N-1:0]  w_next_acc;

  assign w_beat = (r_state == S_ACC) && bus.in_valid;

`ifdef POSIT_ACC_NAR_STICKY_EN
  logic r_nar_seen;
  logic w_nar_hit;

  // Once NaR has been seen the adder output is discarded for the rest of the reduction.
  assign w_nar_hit  = r_nar_seen || (bus.in_data == NAR) || (bus.add_sum == NAR);
  assign w_next_acc = w_nar_hit ? NAR : bus.add_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nar_seen <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_nar_seen <= (bus.init == NAR);
    end else if (w_beat) begin
      r_nar_seen <= w_nar_hit;
    end
  end
`else
  assign w_next_acc = bus.add_sum;
`endif

  // NOTE: all state below uses non-blocking assignments so every register sees
  // pre-edge values of its peers; blocking here would create ordering-dependent logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_remaining <= '0;
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_beat_cnt <= '0;
            if (bus.len != '0) begin
              r_acc       <= bus.init;
              r_remaining <= bus.len;
              r_state     <= S_ACC;
            end else begin
              r_out_data  <= bus.init;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_ACC: begin
          if (w_beat) begin
            r_acc       <= w_next_acc;
            r_remaining <= r_remaining - LW'(1);
            r_beat_cnt  <= r_beat_cnt + LW'(1);
            if (r_remaining == LW'(1)) begin
              r_out_data  <= w_next_acc;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // in_ready and busy decode straight from state so reset clears them without a clock.
  assign bus.in_ready  = (r_state == S_ACC);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.add_a     = r_acc;
  assign bus.add_b     = bus.in_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_posit_accumulator.sv
// Self-checking bench for posit_accumulator with a small table-driven adder model
// feeding add_sum and a scoreboard queue of expected reduction results.
module tb_posit_accumulator;
  localparam int N  = 32;
  localparam int LW = 8;
  localparam logic [N-1:0] NAR   = 32'h8000_0000;
  localparam logic [N-1:0] P_ONE = 32'h4000_0000;
  localparam logic [N-1:0] P_TWO = 32'h4200_0000;
  localparam logic [N-1:0] P_THR = 32'h4300_0000;
  localparam logic [N-1:0] M_ONE = 32'hC000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  posit_accumulator_if #(.N(N), .LW(LW)) bus ();

  posit_accumulator #(.N(N), .ES(4), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_q[$];

  // Posit<32,4> sums for the operand pairs the tests use; NaR absorbs, zero is identity.
  function automatic logic [N-1:0] model_add(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a == NAR || b == NAR) return NAR;
    if (a == '0) return b;
    if (b == '0) return a;
    case ({a, b})
      {P_ONE, P_ONE}: return P_TWO;
      {P_TWO, P_ONE}: return P_THR;
      {P_ONE, M_ONE}: return '0;
      {M_ONE, P_ONE}: return '0;
      default:        return a ^ b;
    endcase
  endfunction

  function automatic logic [N-1:0] exp_reduce(input logic [N-1:0] init,
                                              input logic [N-1:0] ops [4], input int n);
    logic [N-1:0] acc = init;
    logic [N-1:0] s;
    logic nar = (init == NAR);
    for (int i = 0; i < n; i++) begin
      s = model_add(acc, ops[i]);
`ifdef POSIT_ACC_NAR_STICKY_EN
      nar = nar || (ops[i] == NAR) || (s == NAR);
      acc = nar ? NAR : s;
`else
      acc = s;
`endif
    end
    return acc;
  endfunction

  always_comb bus.add_sum = model_add(bus.add_a, bus.add_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LW-1:0] len, input logic [N-1:0] init);
    bus.start = 1'b1;
    bus.len   = len;
    bus.init  = init;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] got;
    bus.start = 0; bus.len = '0; bus.init = '0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    #3;
    got = {bus.in_ready, bus.out_valid, bus.busy};
    n_assert++; if (got !== '0) begin n_fail++; $display("FAIL reset_flags: got %h expected 0", got); end
    n_assert++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    n_assert++; if (bus.beat_cnt !== '0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d expected 0", bus.beat_cnt); end
    n_assert++; if (bus.add_a !== '0) begin n_fail++; $display("FAIL reset_add_a: got %h expected 0", bus.add_a); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_sum();
    logic [N-1:0] ops [4] = '{P_ONE, P_ONE, P_ONE, '0};
    logic [N-1:0] exp;
    exp_q.push_back(exp_reduce('0, ops, 3));
    do_start(3, '0);
    n_assert++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b expected 1", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = ops[i];
      n_assert++; if (bus.add_b !== ops[i]) begin n_fail++; $display("FAIL basic_add_b: got %h expected %h", bus.add_b, ops[i]); end
      tick();
    end
    bus.in_valid = 1'b0;
    n_assert++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: out_valid %b after 4 cycles expected 1", bus.out_valid); end
    exp = exp_q.pop_front();
    n_assert++; if (bus.out_data !== exp) begin n_fail++; $display("FAIL basic_out_data: got %h expected %h", bus.out_data, exp); end
    n_assert++; if (bus.beat_cnt !== 8'd3) begin n_fail++; $display("FAIL basic_beat_cnt: got %0d expected 3", bus.beat_cnt); end
    n_assert++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_done_flags: in_ready %b busy %b expected 0 1", bus.in_ready, bus.busy); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    n_assert++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: out_valid %b busy %b expected 0 0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_len_zero();
    logic [N-1:0] exp;
    exp_q.push_back(P_ONE);
    bus.start = 1'b1; bus.len = '0; bus.init = P_ONE;
    n_assert++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL len0_in_ready_start: got %b expected 0", bus.in_ready); end
    tick(); bus.start = 1'b0;
    n_assert++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL len0_out_valid: got %b expected 1", bus.out_valid); end
    exp = exp_q.pop_front();
    n_assert++; if (bus.out_data !== exp) begin n_fail++; $display("FAIL len0_out_data: got %h expected %h", bus.out_data, exp); end
    n_assert++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL len0_in_ready: got %b expected 0", bus.in_ready); end
    n_assert++; if (bus.add_a !== P_THR) begin n_fail++; $display("FAIL len0_acc_untouched: got %h expected %h", bus.add_a, P_THR); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
  endtask

  task automatic test_bubbles();
    logic [N-1:0] ops [4] = '{P_ONE, M_ONE, '0, '0};
    logic [N-1:0] exp;
    exp_q.push_back(exp_reduce('0, ops, 2));
    do_start(2, '0);
    bus.in_valid = 1'b1; bus.in_data = ops[0]; tick(); bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = $urandom;
      n_assert++; if (bus.add_a !== P_ONE || bus.beat_cnt !== 8'd1) begin n_fail++; $display("FAIL bubble_hold_%0d: acc %h beat_cnt %0d expected %h 1", i, bus.add_a, bus.beat_cnt, P_ONE); end
      tick();
    end
    bus.in_valid = 1'b1; bus.in_data = ops[1]; tick(); bus.in_valid = 1'b0;
    exp = exp_q.pop_front();
    n_assert++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin n_fail++; $display("FAIL bubble_result: valid %b data %h expected 1 %h", bus.out_valid, bus.out_data, exp); end
    n_assert++; if (bus.beat_cnt !== 8'd2) begin n_fail++; $display("FAIL bubble_beat_cnt: got %0d expected 2", bus.beat_cnt); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] ops [4] = '{P_ONE, '0, '0, '0};
    logic [N-1:0] exp;
    exp_q.push_back(exp_reduce(P_ONE, ops, 1));
    do_start(1, P_ONE);
    bus.in_valid = 1'b1; bus.in_data = ops[0]; tick(); bus.in_valid = 1'b0;
    exp = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1; bus.len = 8'd3; bus.init = M_ONE;
      n_assert++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin n_fail++; $display("FAIL bp_hold_%0d: valid %b data %h expected 1 %h", i, bus.out_valid, bus.out_data, exp); end
      n_assert++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp_flags_%0d: in_ready %b busy %b expected 0 1", i, bus.in_ready, bus.busy); end
      tick();
    end
    bus.start = 1'b0; bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    n_assert++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: valid %b busy %b expected 0 0", bus.out_valid, bus.busy); end
    tick();
    n_assert++; if (bus.busy !== 1'b0 || bus.beat_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_start_ignored: busy %b beat_cnt %0d expected 0 1", bus.busy, bus.beat_cnt); end
  endtask

  task automatic test_reset_abort();
    logic [N-1:0] ops [4] = '{P_ONE, '0, '0, '0};
    logic [N-1:0] exp;
    do_start(4, '0);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_data = P_ONE; tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000) begin n_fail++; $display("FAIL abort_flags: in_ready %b valid %b busy %b expected 0", bus.in_ready, bus.out_valid, bus.busy); end
    n_assert++; if (bus.out_data !== '0 || bus.beat_cnt !== '0 || bus.add_a !== '0) begin n_fail++; $display("FAIL abort_regs: data %h beat_cnt %0d acc %h expected 0", bus.out_data, bus.beat_cnt, bus.add_a); end
    tick();
    n_assert++; if (bus.out_valid !== 1'b0 || bus.beat_cnt !== '0) begin n_fail++; $display("FAIL abort_held: valid %b beat_cnt %0d expected 0 0", bus.out_valid, bus.beat_cnt); end
    bus.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    exp_q.push_back(exp_reduce(P_ONE, ops, 1));
    do_start(1, P_ONE);
    bus.in_valid = 1'b1; bus.in_data = ops[0]; tick(); bus.in_valid = 1'b0;
    exp = exp_q.pop_front();
    n_assert++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin n_fail++; $display("FAIL abort_restart: valid %b data %h expected 1 %h", bus.out_valid, bus.out_data, exp); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
  endtask

  task automatic test_nar();
    logic [N-1:0] ops [4] = '{P_ONE, NAR, P_ONE, '0};
    logic [N-1:0] exp;
    exp_q.push_back(exp_reduce('0, ops, 3));
    do_start(3, '0);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = ops[i]; tick();
    end
    bus.in_valid = 1'b0;
    exp = exp_q.pop_front();
    n_assert++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin n_fail++; $display("FAIL nar_result: valid %b data %h expected 1 %h", bus.out_valid, bus.out_data, exp); end
    n_assert++; if (bus.out_data !== NAR) begin n_fail++; $display("FAIL nar_is_nar: got %h expected %h", bus.out_data, NAR); end
    n_assert++; if (bus.beat_cnt !== 8'd3) begin n_fail++; $display("FAIL nar_beat_cnt: got %0d expected 3", bus.beat_cnt); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_len_zero();
    test_bubbles();
    test_back_pressure();
    test_reset_abort();
    test_nar();
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
